// File: rtl/riscv_fetch_pkg.sv
// riscv_fetch_pkg: shared fetch-stage types, constants and the request credit rule
package riscv_fetch_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fetch_state_e;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam int FETCH_FIFO_DEPTH = 2;
  function automatic logic has_credit(input logic [1:0] entries, input logic outstanding);
    return 32'(entries) + 32'(outstanding) < FETCH_FIFO_DEPTH;
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: two-entry {pc, instruction} FIFO with the head kept in slot 0; flush overrides push and pop
module fetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [AW-1:0] push_pc_i,
  input  logic [31:0]   push_instr_i,
  output logic [AW-1:0] head_pc_o,
  output logic [31:0]   head_instr_o,
  output logic [1:0]    count_o
);
  logic [AW-1:0] pc_q [2];
  logic [AW-1:0] pc_d [2];
  logic [31:0] instr_q [2];
  logic [31:0] instr_d [2];
  logic [1:0] count_q, count_d;
  logic pop, push, full, wsel;
  always_comb begin
    pop = pop_i && count_q != 2'd0;
    full = count_q == 2'(FETCH_FIFO_DEPTH);
    push = push_i && (!full || pop);
    wsel = full || (count_q == 2'd1 && !pop);
    count_d = flush_i ? 2'd0 : count_q + 2'(push) - 2'(pop);
    pc_d = pc_q;
    instr_d = instr_q;
    if (!flush_i && pop && full) begin
      pc_d[0] = pc_q[1];
      instr_d[0] = instr_q[1];
    end
    if (!flush_i && push) begin
      pc_d[wsel] = push_pc_i;
      instr_d[wsel] = push_instr_i;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      pc_q <= '{default: '0};
      instr_q <= '{default: NOP_INSTR};
    end else begin
      count_q <= count_d;
      pc_q <= pc_d;
      instr_q <= instr_d;
    end
  end
  assign head_pc_o = pc_q[0];
  assign head_instr_o = instr_q[0];
  assign count_o = count_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC and imem handshake FSM feeding a 2-deep decode buffer; FETCH_PERF_CNT_EN adds a consumed-instruction counter
module fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter int                      ADDRESS_BITS = 16,
  parameter logic [ADDRESS_BITS-1:0] BOOT_ADDR    = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    imem_req_o,
  output logic [ADDRESS_BITS-1:0] imem_addr_o,
  input  logic                    imem_gnt_i,
  input  logic                    imem_rvalid_i,
  input  logic [31:0]             imem_rdata_i,
  input  logic                    redirect_i,
  input  logic [ADDRESS_BITS-1:0] redirect_pc_i,
  output logic                    instr_valid_o,
  input  logic                    instr_ready_i,
  output logic [ADDRESS_BITS-1:0] pc_o,
  output logic [31:0]             instruction_o,
  output logic [31:0]             fetch_count_o
);
  fetch_state_e state_q, state_d;
  logic [ADDRESS_BITS-1:0] fetch_pc_q, fetch_pc_d;
  logic kill_q, kill_d, push, pop, in_flight, unused_bits;
  logic [1:0] count, count_next;
  assign unused_bits = ^redirect_pc_i[1:0];
  assign push = state_q == WAIT && imem_rvalid_i && !kill_q;
  assign pop = instr_valid_o && instr_ready_i;
  assign count_next = count + 2'(push) - 2'(pop);
  assign instr_valid_o = count != 2'd0;
  assign imem_req_o = state_q == REQ;
  assign imem_addr_o = fetch_pc_q;
  always_comb begin
    state_d = state_q;
    fetch_pc_d = fetch_pc_q;
    kill_d = kill_q;
    in_flight = (state_q == WAIT && !imem_rvalid_i) || (state_q == REQ && imem_gnt_i);
    case (state_q)
      IDLE: state_d = REQ;
      REQ: if (imem_gnt_i) begin
        fetch_pc_d = fetch_pc_q + ADDRESS_BITS'(4);
        state_d = WAIT;
      end
      WAIT: if (imem_rvalid_i) begin
        kill_d = 1'b0;
        state_d = has_credit(count_next, in_flight) ? REQ : HOLD;
      end
      HOLD: state_d = has_credit(count_next, in_flight) ? REQ : HOLD;
      default: state_d = IDLE;
    endcase
    // a response that lands in the redirect cycle is already gone, so it must not leave kill armed
    if (redirect_i) begin
      fetch_pc_d = {redirect_pc_i[ADDRESS_BITS-1:2], 2'b00};
      kill_d = in_flight;
      state_d = in_flight ? WAIT : REQ;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fetch_pc_q <= BOOT_ADDR;
      kill_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      kill_q <= kill_d;
    end
  end
  fetch_fifo #(.AW(ADDRESS_BITS)) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (redirect_i),
    .push_i       (push),
    .pop_i        (pop),
    .push_pc_i    (fetch_pc_q - ADDRESS_BITS'(4)),
    .push_instr_i (imem_rdata_i),
    .head_pc_o    (pc_o),
    .head_instr_o (instruction_o),
    .count_o      (count)
  );
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  assign fetch_count_d = fetch_count_q + 32'(pop && !redirect_i);
  always_ff @(posedge clk) begin
    if (!rst_n) fetch_count_q <= '0;
    else fetch_count_q <= fetch_count_d;
  end
  assign fetch_count_o = fetch_count_q;
`else
  assign fetch_count_o = '0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit against a latency-configurable instruction memory
module tb_fetch_unit;
  localparam int AW = 16;
`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic imem_req_o, imem_gnt_i = 1'b0, imem_rvalid_i = 1'b0;
  logic redirect_i = 1'b0, instr_valid_o, instr_ready_i = 1'b0;
  logic [AW-1:0] imem_addr_o, redirect_pc_i = '0, pc_o;
  logic [31:0] imem_rdata_i = '0, instruction_o, fetch_count_o;
  int n_vec = 0, n_err = 0, n_pop = 0, lat = 1, dly = 0;
  bit pend = 1'b0, got = 1'b0;
  logic [AW-1:0] paddr = '0, e_pc;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] gnt_log[$];

  always #5 clk = ~clk;

  fetch_unit #(.ADDRESS_BITS(AW), .BOOT_ADDR(16'h0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .pc_o          (pc_o),
    .instruction_o (instruction_o),
    .fetch_count_o (fetch_count_o)
  );

  function automatic logic [31:0] word(input logic [AW-1:0] a);
    return {~a, a};
  endfunction

  function automatic logic [31:0] exp_cnt(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // memory drives at negedge+0, stimulus at +1, monitor samples at +2
  initial forever begin
    @(negedge clk);
    imem_rvalid_i = 1'b0;
    if (!rst_n) pend = 1'b0;
    if (pend) begin
      dly--;
      if (dly == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i = word(paddr);
        pend = 1'b0;
      end
    end
    imem_gnt_i = imem_req_o && !pend;
    if (imem_gnt_i) begin
      pend = 1'b1;
      dly = lat;
      paddr = imem_addr_o;
      gnt_log.push_back(imem_addr_o);
    end
  end

  initial forever begin
    @(negedge clk);
    #2;
    if (rst_n && instr_valid_o && instr_ready_i && !redirect_i) begin
      n_pop++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL pop: unexpected pc %h, expected none", pc_o);
      end else begin
        e_pc = exp_q.pop_front();
        chk("pop_pc", 32'(pc_o), 32'(e_pc));
        chk("pop_instr", instruction_o, word(e_pc));
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic seed(input logic [AW-1:0] start);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(start + AW'(4 * i));
  endtask

  task automatic redirect(input logic [AW-1:0] t);
    redirect_i = 1'b1;
    redirect_pc_i = t;
    seed({t[AW-1:2], 2'b00});
    gnt_log.delete();
    cyc();
    redirect_i = 1'b0;
  endtask

  task automatic wait_gnt(input string name);
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      cyc();
      got = imem_gnt_i;
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: no grant within 50 cycles, got none expected one", name);
    end
  endtask

  initial begin
    repeat (3) cyc();
    chk("rst_req", 32'(imem_req_o), 0);
    chk("rst_addr", 32'(imem_addr_o), 0);
    chk("rst_valid", 32'(instr_valid_o), 0);
    chk("rst_pc", 32'(pc_o), 0);
    chk("rst_instr", instruction_o, 32'h00000013);
    chk("rst_count", fetch_count_o, 0);
    // boot stream with single-cycle memory
    seed(16'h0000);
    instr_ready_i = 1'b1;
    rst_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      cyc();
      chk("boot_valid", 32'(instr_valid_o), 32'(c == 3));
      if (c == 1) begin
        chk("boot_req", 32'(imem_req_o), 1);
        chk("boot_addr", 32'(imem_addr_o), 0);
      end
    end
    repeat (8) cyc();
    for (int i = 0; i < 3; i++) chk("boot_gnt_addr", 32'(gnt_log[i]), 32'(4 * i));
    chk("boot_count", fetch_count_o, exp_cnt(n_pop));
    // decode stall fills both slots and parks the FSM in HOLD
    instr_ready_i = 1'b0;
    repeat (10) cyc();
    chk("stall_valid", 32'(instr_valid_o), 1);
    chk("stall_req", 32'(imem_req_o), 0);
    instr_ready_i = 1'b1;
    cyc();
    chk("drain1_valid", 32'(instr_valid_o), 1);
    chk("drain1_req", 32'(imem_req_o), 1);
    cyc();
    chk("drain2_valid", 32'(instr_valid_o), 0);
    chk("drain2_req", 32'(imem_req_o), 0);
    cyc();
    chk("drain3_valid", 32'(instr_valid_o), 1);
    // redirect while a slow response is outstanding
    lat = 3;
    wait_gnt("t3_gnt");
    cyc();
    redirect(16'h0102);
    chk("t3_req_kill", 32'(imem_req_o), 0);
    chk("t3_valid_flush", 32'(instr_valid_o), 0);
    cyc();
    chk("t3_valid_drop", 32'(instr_valid_o), 0);
    chk("t3_req_wait", 32'(imem_req_o), 0);
    cyc();
    chk("t3_req", 32'(imem_req_o), 1);
    chk("t3_addr", 32'(imem_addr_o), 32'h0100);
    chk("t3_valid_none", 32'(instr_valid_o), 0);
    repeat (12) cyc();
    chk("t3_gnt0", 32'(gnt_log[0]), 32'h0100);
    chk("t3_gnt1", 32'(gnt_log[1]), 32'h0104);
    // redirect coinciding with a pop and a grant
    lat = 1;
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      cyc();
      got = instr_valid_o && imem_gnt_i;
    end
    chk("t4_found", 32'(got), 1);
    redirect(16'h0200);
    chk("t4_valid", 32'(instr_valid_o), 0);
    chk("t4_req", 32'(imem_req_o), 0);
    chk("t4_count", fetch_count_o, exp_cnt(n_pop));
    cyc();
    chk("t4_req2", 32'(imem_req_o), 1);
    chk("t4_addr", 32'(imem_addr_o), 32'h0200);
    chk("t4_valid2", 32'(instr_valid_o), 0);
    repeat (10) cyc();
    chk("t4_gnt0", 32'(gnt_log[0]), 32'h0200);
    // address wrap at the top of the space, low target bits ignored
    redirect(16'hFFFF);
    repeat (12) cyc();
    chk("wrap_gnt0", 32'(gnt_log[0]), 32'hFFFC);
    chk("wrap_gnt1", 32'(gnt_log[1]), 32'h0000);
    chk("wrap_gnt2", 32'(gnt_log[2]), 32'h0004);
    // reset mid-stream, then exactly five pops
    rst_n = 1'b0;
    repeat (2) cyc();
    chk("rst2_req", 32'(imem_req_o), 0);
    chk("rst2_addr", 32'(imem_addr_o), 0);
    chk("rst2_valid", 32'(instr_valid_o), 0);
    chk("rst2_pc", 32'(pc_o), 0);
    chk("rst2_instr", instruction_o, 32'h00000013);
    chk("rst2_count", fetch_count_o, 0);
    seed(16'h0000);
    gnt_log.delete();
    n_pop = 0;
    rst_n = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      cyc();
      got = n_pop == 5;
    end
    instr_ready_i = 1'b0;
    chk("five_pops", 32'(got), 1);
    cyc();
    chk("count5", fetch_count_o, exp_cnt(5));
    repeat (3) cyc();
    chk("count5_hold", fetch_count_o, exp_cnt(5));
    chk("rst2_gnt0", 32'(gnt_log[0]), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
